// File: rtl/tetris_pkg.sv
// Shared board geometry and the line-clear sequencer state encoding.
// The board, the GPU and the line-clear logic all take their dimensions from here.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int CNT_W   = $clog2(BOARD_H + 1);
    localparam int ROW_W   = $clog2(BOARD_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/row_full_sel.sv
// Picks one board row out of the flat occupancy vector and reports whether every cell in it is set.
// Purely combinational so it can also serve the game-over check.
module row_full_sel
    import tetris_pkg::*;
(
    input  logic [BOARD_W*BOARD_H-1:0] cell_occ,
    input  logic [ROW_W-1:0]           row_idx,
    output logic                       row_full
);

    // An out-of-range index yields 0 rather than aliasing onto a real row.
    always_comb begin
        row_full = 1'b0;
        for (int r = 0; r < BOARD_H; r++) begin
            if (row_idx == ROW_W'(r)) begin
                row_full = &cell_occ[r*BOARD_W +: BOARD_W];
            end
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Row-clear sequencer: after a piece lock it scans the board bottom-up and collapses every full
// row by strobing the advance lines of that row and every row above it, then reports the count.
module line_clear_ctrl
    import tetris_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [BOARD_W*BOARD_H-1:0] cell_occ,
    input  logic                       start,
    output logic [BOARD_H-1:0]         advance_rows,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           lines_cleared
);

    state_t           state;
    logic [ROW_W-1:0] row_idx;
    logic [CNT_W-1:0] count;
    logic             row_full;

    row_full_sel u_row_full_sel (
        .cell_occ (cell_occ),
        .row_idx  (row_idx),
        .row_full (row_full)
    );

    // Rows 0..idx all move down one; the row below idx is untouched.
    function automatic logic [BOARD_H-1:0] fill_mask(input logic [ROW_W-1:0] idx);
        logic [BOARD_H-1:0] m;
        m = '0;
        for (int r = 0; r < BOARD_H; r++) begin
            m[r] = (ROW_W'(r) <= idx);
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_W'(BOARD_H)) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            row_idx       <= ROW_W'(BOARD_H - 1);
            count         <= '0;
            advance_rows  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
        end else begin
            done         <= 1'b0;
            advance_rows <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SCAN;
                        row_idx <= ROW_W'(BOARD_H - 1);
                        count   <= '0;
                        busy    <= 1'b1;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        state        <= SHIFT;
                        advance_rows <= fill_mask(row_idx);
                        count        <= sat_inc(count);
                    end else if (row_idx == '0) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        lines_cleared <= count;
                        busy          <= 1'b0;
                    end else begin
                        row_idx <= row_idx - 1'b1;
                    end
                end
                // The collapsed row now holds the contents of the row above, so rescan it.
                SHIFT: begin
                    state <= SCAN;
                end
                DONE: begin
                    state   <= IDLE;
                    row_idx <= ROW_W'(BOARD_H - 1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a behavioural board that obeys the advance strobes.
module tb_line_clear_ctrl;
    import tetris_pkg::*;

    localparam int NB = BOARD_W * BOARD_H;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [NB-1:0]        board;
    logic [BOARD_H-1:0]   advance_rows;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     lines_cleared;

    logic                 load_en;
    logic [NB-1:0]        load_val;

    int n_checks;
    int n_fail;

    logic [BOARD_H-1:0] mask_q[$];
    int                 mask_cyc_q[$];

    line_clear_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .cell_occ      (board),
        .start         (start),
        .advance_rows  (advance_rows),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board model: an advanced row takes the row above; row 0 takes zeros.
    always @(posedge clk) begin
        if (load_en) begin
            board <= load_val;
        end else begin
            for (int r = 0; r < BOARD_H; r++) begin
                if (advance_rows[r]) begin
                    if (r == 0) board[r*BOARD_W +: BOARD_W] <= '0;
                    else        board[r*BOARD_W +: BOARD_W] <= board[(r-1)*BOARD_W +: BOARD_W];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] set_row(input logic [NB-1:0] b, input int r,
                                              input logic [BOARD_W-1:0] v);
        logic [NB-1:0] t;
        t = b;
        t[r*BOARD_W +: BOARD_W] = v;
        return t;
    endfunction

    function automatic logic [BOARD_W-1:0] get_row(input logic [NB-1:0] b, input int r);
        return b[r*BOARD_W +: BOARD_W];
    endfunction

    task automatic load(input logic [NB-1:0] v);
        @(negedge clk);
        load_val = v;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the edge that samples start.
    task automatic run(input int restart_cyc, input int post,
                       output int done_cyc, output int lines, output int busy_cnt, output int extra);
        mask_q.delete();
        mask_cyc_q.delete();
        done_cyc = -1;
        lines    = -1;
        busy_cnt = 0;
        extra    = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 80 && done_cyc < 0; c++) begin
            if (c > 1) @(negedge clk);
            start = (restart_cyc == c);
            if (advance_rows != '0) begin
                mask_q.push_back(advance_rows);
                mask_cyc_q.push_back(c);
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = c;
                lines    = int'(lines_cleared);
                if (restart_cyc < 0) start = 1'b1;
            end
        end
        if (done_cyc < 0) chk("done_timeout", 32'(done_cyc), 32'd1);
        for (int p = 0; p < post; p++) begin
            @(negedge clk);
            start = 1'b0;
            if (done || busy) extra++;
        end
        start = 1'b0;
    endtask

    int            dc, ln, bc, ex;
    logic [NB-1:0] b;
    logic [NB-1:0] exp_b;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        load_en  = 1'b0;
        load_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_adv",   32'(advance_rows),  32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(done),          32'd0);
        chk("rst_lines", 32'(lines_cleared), 32'd0);
        reset = 1'b0;

        // Empty board
        load('0);
        run(0, 3, dc, ln, bc, ex);
        chk("t1_done_cyc", 32'(dc), 32'd21);
        chk("t1_lines",    32'(ln), 32'd0);
        chk("t1_nmask",    32'(mask_q.size()), 32'd0);
        chk("t1_busy_cnt", 32'(bc), 32'd20);
        chk("t1_post",     32'(ex), 32'd0);

        // Only row 19 full
        b = set_row('0, 19, '1);
        b = set_row(b, 18, 10'h155);
        load(b);
        run(0, 2, dc, ln, bc, ex);
        chk("t2_done_cyc", 32'(dc), 32'd23);
        chk("t2_lines",    32'(ln), 32'd1);
        chk("t2_nmask",    32'(mask_q.size()), 32'd1);
        if (mask_q.size() > 0) begin
            chk("t2_mask",     32'(mask_q[0]), 32'hFFFFF);
            chk("t2_mask_cyc", 32'(mask_cyc_q[0]), 32'd2);
        end
        chk("t2_row19", 32'(get_row(board, 19)), 32'h155);
        chk("t2_row18", 32'(get_row(board, 18)), 32'h0);

        // Rows 16-19 full
        b = '0;
        for (int r = 16; r < 20; r++) b = set_row(b, r, '1);
        load(b);
        run(0, 2, dc, ln, bc, ex);
        chk("t3_done_cyc", 32'(dc), 32'd29);
        chk("t3_lines",    32'(ln), 32'd4);
        chk("t3_nmask",    32'(mask_q.size()), 32'd4);
        for (int i = 0; i < mask_q.size(); i++) begin
            chk($sformatf("t3_mask%0d", i),     32'(mask_q[i]), 32'hFFFFF);
            chk($sformatf("t3_mask_cyc%0d", i), 32'(mask_cyc_q[i]), 32'(2 + 2*i));
        end
        chk("t3_board", 32'(board[NB-1 -: 4*BOARD_W] != '0), 32'd0);

        // Rows 10 and 15 full, a marker in row 12
        b = set_row('0, 10, '1);
        b = set_row(b, 15, '1);
        b = set_row(b, 12, 10'h3FE);
        load(b);
        run(0, 2, dc, ln, bc, ex);
        chk("t4_done_cyc", 32'(dc), 32'd25);
        chk("t4_lines",    32'(ln), 32'd2);
        chk("t4_nmask",    32'(mask_q.size()), 32'd2);
        if (mask_q.size() > 1) begin
            chk("t4_mask0", 32'(mask_q[0]), 32'h0FFFF);
            chk("t4_mask1", 32'(mask_q[1]), 32'h00FFF);
        end
        exp_b = set_row('0, 13, 10'h3FE);
        chk("t4_board", 32'(board == exp_b), 32'd1);

        // Only row 0 full
        load(set_row('0, 0, '1));
        run(0, 2, dc, ln, bc, ex);
        chk("t5_done_cyc", 32'(dc), 32'd23);
        chk("t5_lines",    32'(ln), 32'd1);
        chk("t5_nmask",    32'(mask_q.size()), 32'd1);
        if (mask_q.size() > 0) begin
            chk("t5_mask",     32'(mask_q[0]), 32'h00001);
            chk("t5_mask_cyc", 32'(mask_cyc_q[0]), 32'd21);
        end
        chk("t5_board", 32'(board == '0), 32'd1);

        // Reset asserted during a SHIFT cycle
        load(set_row('0, 19, '1));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t6_adv_live", 32'(advance_rows), 32'hFFFFF);
        reset = 1'b1;
        #1;
        chk("t6_rst_adv",   32'(advance_rows),  32'd0);
        chk("t6_rst_busy",  32'(busy),          32'd0);
        chk("t6_rst_done",  32'(done),          32'd0);
        chk("t6_rst_lines", 32'(lines_cleared), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("t6_row19_kept", 32'(get_row(board, 19)), 32'h3FF);
        run(0, 2, dc, ln, bc, ex);
        chk("t6_done_cyc", 32'(dc), 32'd23);
        chk("t6_lines",    32'(ln), 32'd1);

        // start pulsed mid-scan is ignored
        load('0);
        run(5, 25, dc, ln, bc, ex);
        chk("t7_done_cyc", 32'(dc), 32'd21);
        chk("t7_lines",    32'(ln), 32'd0);
        chk("t7_extra",    32'(ex), 32'd0);

        // start in the DONE cycle is ignored
        run(-1, 5, dc, ln, bc, ex);
        chk("t8_done_cyc", 32'(dc), 32'd21);
        chk("t8_extra",    32'(ex), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
